processor_clock_control: RTL

- Sits directly downstream of the clock divider. Consumes the divided `clock_out` waveform as a data signal on `slow_clock`. It is never used as a clock.
- Converts it into a single-cycle `cpu_enable` strobe in the `clock_in` domain, so the processor runs on one FPGA clock.
- Adds board-level run/step/halt control: a run switch, a debounced single-step push button, and a halt request from the processor.
- Counts executed processor cycles for display and debug.

---
 rtl/processor_clock_control_pkg.sv | 15 +
 rtl/processor_clock_control_button_debouncer.sv | 65 ++++++
 rtl/processor_clock_control.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/processor_clock_control_pkg.sv
// Shared definitions for the processor clock-control block.
//   pcc_state_e : run/step/halt state machine encoding
//   CYCLE_W     : width of the executed-cycle counter
package processor_clock_control_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RUN        = 2'd1,
    STEP_ARMED = 2'd2,
    HALTED     = 2'd3
  } pcc_state_e;

  localparam int CYCLE_W = 32;

endpackage

// File: rtl/processor_clock_control_button_debouncer.sv
// Push-button conditioner: two-flop synchronizer, stability counter and
// a one-cycle pulse on each accepted press (release produces nothing).
// Ports:
//   clock_in     : system clock
//   reset        : synchronous, active-high
//   button       : raw, bouncing, asynchronous button level (active-high)
//   button_level : debounced level
//   press_pulse  : one-cycle strobe on debounced 0->1
module button_debouncer #(
  parameter int unsigned           DEB_W           = 20,
  parameter logic [DEB_W-1:0]      DEBOUNCE_CYCLES = 20'd1000000
) (
  input  logic clock_in,
  input  logic reset,
  input  logic button,
  output logic button_level,
  output logic press_pulse
);

  localparam logic [DEB_W-1:0] CNT_MAX = DEBOUNCE_CYCLES - DEB_W'(1);

  logic             btn_p0;
  logic             btn_p1;
  logic [DEB_W-1:0] deb_cnt;
  logic             deb_level;
  logic             pulse;

  // stage p0/p1: synchronizer
  always_ff @(posedge clock_in) begin
    if (reset) begin
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
    end else begin
      btn_p0 <= button;
      btn_p1 <= btn_p0;
    end
  end

  // stage p2: stability counter; the level flips only after CNT_MAX+1
  // consecutive cycles of disagreement, any agreement restarts the count
  always_ff @(posedge clock_in) begin
    if (reset) begin
      deb_cnt   <= '0;
      deb_level <= 1'b0;
      pulse     <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (btn_p1 != deb_level) begin
        if (deb_cnt == CNT_MAX) begin
          deb_cnt   <= '0;
          deb_level <= ~deb_level;
          pulse     <= ~deb_level;
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign button_level = deb_level;
  assign press_pulse  = pulse;

endmodule

// File: rtl/processor_clock_control.sv
// Turns the divided-clock waveform into a one-cycle processor enable in
// the clock_in domain, with run / single-step / halt control and an
// executed-cycle counter.
// Ports:
//   clock_in     : FPGA system clock (only clock)
//   reset        : synchronous, active-high
//   slow_clock   : divided-clock waveform, sampled as asynchronous data
//   run_switch   : 1 = free run, 0 = stop/step (asynchronous)
//   step_button  : raw single-step push button (asynchronous, bouncing)
//   halt_request : HLT decoded by the processor (clock_in domain)
//   cpu_enable   : one-cycle strobe per processor step
//   halted       : high while halted
//   cycle_count  : number of cpu_enable pulses since reset (wraps)
module processor_clock_control
  import processor_clock_control_pkg::*;
#(
  parameter int unsigned      DEB_W           = 20,
  parameter logic [DEB_W-1:0] DEBOUNCE_CYCLES = 20'd1000000
) (
  input  logic               clock_in,
  input  logic               reset,
  input  logic               slow_clock,
  input  logic               run_switch,
  input  logic               step_button,
  input  logic               halt_request,
  output logic               cpu_enable,
  output logic               halted,
  output logic [CYCLE_W-1:0] cycle_count
);

  logic               slow_p0;
  logic               slow_p1;
  logic               slow_p2;
  logic               tick_p3;
  logic               run_p0;
  logic               run_p1;
  logic               step_pulse;
  logic               step_level;
  pcc_state_e         state;
  logic               enable_r;
  logic               halted_r;
  logic               chk_r;
  logic               fired_r;
  logic [CYCLE_W-1:0] cycle_cnt;

  button_debouncer #(
    .DEB_W           (DEB_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_step_debouncer (
    .clock_in     (clock_in),
    .reset        (reset),
    .button       (step_button),
    .button_level (step_level),
    .press_pulse  (step_pulse)
  );

  // stage p0..p3: synchronizers and registered rising-edge tick
  always_ff @(posedge clock_in) begin
    if (reset) begin
      slow_p0 <= 1'b0;
      slow_p1 <= 1'b0;
      slow_p2 <= 1'b0;
      tick_p3 <= 1'b0;
      run_p0  <= 1'b0;
      run_p1  <= 1'b0;
    end else begin
      slow_p0 <= slow_clock;
      slow_p1 <= slow_p0;
      slow_p2 <= slow_p1;
      tick_p3 <= slow_p1 & ~slow_p2;
      run_p0  <= run_switch;
      run_p1  <= run_p0;
    end
  end

  // control FSM: chk_r marks the cycle after a pulse, when the processor's
  // halt decision for the instruction just executed is visible
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state    <= IDLE;
      enable_r <= 1'b0;
      halted_r <= 1'b0;
      chk_r    <= 1'b0;
      fired_r  <= 1'b0;
    end else begin
      enable_r <= 1'b0;
      chk_r    <= enable_r;
      unique case (state)
        IDLE: begin
          fired_r <= 1'b0;
          if (run_p1) begin
            state <= RUN;
          end else if (step_pulse) begin
            state <= STEP_ARMED;
          end
        end
        RUN: begin
          if (chk_r && halt_request) begin
            state    <= HALTED;
            halted_r <= 1'b1;
          end else begin
            if (tick_p3) begin
              enable_r <= 1'b1;
            end
            if (!run_p1) begin
              state <= IDLE;
            end
          end
        end
        STEP_ARMED: begin
          // stay here until the single pulse has had its halt check
          if (chk_r) begin
            fired_r <= 1'b0;
            if (halt_request) begin
              state    <= HALTED;
              halted_r <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (tick_p3 && !fired_r) begin
            enable_r <= 1'b1;
            fired_r  <= 1'b1;
          end
        end
        HALTED: begin
          if (step_pulse && !run_p1) begin
            state    <= IDLE;
            halted_r <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (enable_r) begin
      cycle_cnt <= cycle_cnt + CYCLE_W'(1);
    end
  end

  assign cpu_enable  = enable_r;
  assign halted      = halted_r;
  assign cycle_count = cycle_cnt;

endmodule
